// File: rtl/adder_checker.sv
// rtl/adder_checker.sv - latency-aligned self-checking monitor for an adder DUT
module adder_checker #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 0,
    parameter int NUM_VEC = 7,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH:0]   fail_exp,
    output logic [WIDTH:0]   fail_got,
    output logic             done,
    output logic             pass,
    output logic             overrun
);
    localparam int EW = WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [EW-1:0] exp_now;
    logic          d_valid;
    logic [EW-1:0] d_exp;
    logic [EW-1:0] got;

    assign exp_now = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign got     = {cout, sum};

    // Expected value travels alongside its valid so it meets the DUT result at compare time
    generate
        if (LATENCY == 0) begin : g_comb
            assign d_valid = in_valid;
            assign d_exp   = exp_now;
        end else begin : g_pipe
            logic [LATENCY-1:0] vpipe;
            logic [EW-1:0]      epipe [LATENCY];

            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    vpipe <= '0;
                    for (int i = 0; i < LATENCY; i++) epipe[i] <= '0;
                end else begin
                    vpipe[0] <= in_valid;
                    epipe[0] <= exp_now;
                    for (int i = 1; i < LATENCY; i++) begin
                        vpipe[i] <= vpipe[i-1];
                        epipe[i] <= epipe[i-1];
                    end
                end
            end

            assign d_valid = vpipe[LATENCY-1];
            assign d_exp   = epipe[LATENCY-1];
        end
    endgenerate

    logic             cmp_en;
    logic             mismatch;
    logic             last;
    logic [CNT_W-1:0] vec_nxt;
    logic [CNT_W-1:0] err_nxt;

    // With zero latency the very first vector is compared while still in IDLE
    always_comb begin
        cmp_en    = d_valid && (state != DONE);
        mismatch  = cmp_en && (got !== d_exp);
        vec_nxt   = vec_cnt + 1'b1;
        last      = cmp_en && (vec_nxt == CNT_W'(NUM_VEC));
        err_nxt   = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (last)          state_nxt = DONE;
                else if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            vec_cnt  <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            fail_exp <= '0;
            fail_got <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (cmp_en) begin
                vec_cnt <= vec_nxt;
                err_cnt <= err_nxt;
                // err_cnt saturates rather than wraps, so zero reliably marks "no failure yet"
                if (mismatch && (err_cnt == '0)) begin
                    fail_idx <= vec_cnt;
                    fail_exp <= d_exp;
                    fail_got <= got;
                end
                if (last) begin
                    done <= 1'b1;
                    pass <= (err_nxt == '0);
                end
            end
            if ((state == DONE) && in_valid) overrun <= 1'b1;
        end
    end
endmodule
